// File: rtl/pipeline_pkg.sv
// Shared constants for the 4-stage pipeline: instruction/immediate geometry and
// the program-loader state encodings.
package pipeline_pkg;
  localparam int INSTR_W = 8;
  localparam int IMM_W   = 3;
  localparam int IMM_LSB = 0;
  localparam int UPPER_W = INSTR_W - IMM_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/imm_enc.sv
// Combinational immediate encoder: inverse of the decode-stage sign-extender.
// imm_ok is set only when re-extending the truncated field reproduces s_imm exactly.
module imm_enc
  import pipeline_pkg::*;
#(
  parameter int INSTR_W = pipeline_pkg::INSTR_W,
  parameter int IMM_W   = pipeline_pkg::IMM_W
) (
  input  logic        [INSTR_W-IMM_W-1:0] s_upper,
  input  logic signed [INSTR_W-1:0]       s_imm,
  output logic        [INSTR_W-1:0]       instr,
  output logic                            imm_ok
);

  logic signed [INSTR_W-1:0] imm_ext;

  assign instr   = {s_upper, s_imm[IMM_LSB+IMM_W-1:IMM_LSB]};
  assign imm_ext = {{(INSTR_W-IMM_W){s_imm[IMM_W-1]}}, s_imm[IMM_W-1:0]};
  assign imm_ok  = (imm_ext == s_imm);

endmodule

// File: rtl/imm_enc_loader.sv
// Program loader: encodes host beats into 8-bit instructions and streams them into
// the imem write port, tracking out-of-range immediates for the current load.
module imm_enc_loader
  import pipeline_pkg::*;
#(
  parameter int INSTR_W = pipeline_pkg::INSTR_W,
  parameter int IMM_W   = pipeline_pkg::IMM_W,
  parameter int DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic        [INSTR_W-IMM_W-1:0] s_upper,
  input  logic signed [INSTR_W-1:0]    s_imm,
  input  logic                         s_last,
  output logic                         mem_we,
  output logic [$clog2(DEPTH)-1:0]     mem_addr,
  output logic [INSTR_W-1:0]           mem_wdata,
  output logic                         done,
  output logic [$clog2(DEPTH):0]       wr_count,
  output logic                         err,
  output logic [3:0]                   err_count,
  output logic [$clog2(DEPTH)-1:0]     err_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]         state;
  logic [AW-1:0]      wr_ptr;
  logic [INSTR_W-1:0] instr;
  logic               imm_ok;
  logic               accept;
  logic               last_word;

  imm_enc #(
    .INSTR_W (INSTR_W),
    .IMM_W   (IMM_W)
  ) u_enc (
    .s_upper (s_upper),
    .s_imm   (s_imm),
    .instr   (instr),
    .imm_ok  (imm_ok)
  );

  assign s_ready   = (state == ST_LOAD);
  assign done      = (state == ST_DONE);
  assign accept    = s_valid && s_ready;
  // Either an explicit end marker or a full memory finishes the load; never wrap.
  assign last_word = s_last || (wr_ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_count  <= '0;
      err       <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= wr_ptr;
        mem_wdata <= instr;
        wr_ptr    <= wr_ptr + AW'(1);
        wr_count  <= wr_count + CW'(1);
        if (!imm_ok) begin
          err <= 1'b1;
          if (err_count != 4'hF) err_count <= err_count + 4'd1;
          if (!err) err_addr <= wr_ptr;
        end
        if (last_word) state <= ST_DONE;
      end
      // start is only honoured outside LOAD, so it never races an accepted beat.
      if (start && (state != ST_LOAD)) begin
        state     <= ST_LOAD;
        wr_ptr    <= '0;
        wr_count  <= '0;
        err       <= 1'b0;
        err_count <= '0;
        err_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imm_enc_loader.sv
// Directed bench for imm_enc_loader: encode, range errors, end-of-load, restart,
// full-memory stop, random legal immediates, error saturation and mid-load reset.
module tb_imm_enc_loader;
  localparam int INSTR_W = 8;
  localparam int IMM_W   = 3;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [4:0]        s_upper = '0;
  logic [7:0]        s_imm = '0;
  logic              s_last = 1'b0;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wdata;
  logic              done;
  logic [AW:0]       wr_count;
  logic              err;
  logic [3:0]        err_count;
  logic [AW-1:0]     err_addr;

  int checks = 0;
  int failures = 0;

  imm_enc_loader #(.INSTR_W(INSTR_W), .IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_upper(s_upper), .s_imm(s_imm), .s_last(s_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .wr_count(wr_count),
    .err(err), .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] se3(input logic [2:0] f);
    return {{5{f[2]}}, f};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; start = 1'b0; s_last = 1'b0;
    tick(); tick();
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%0h exp=0", s_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err); end
    checks++; if (wr_count !== 5'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (mem_addr !== 4'd0 || mem_wdata !== 8'h00 || err_addr !== 4'd0) begin
      failures++; $display("FAIL reset_data got addr=%0d wdata=%0h err_addr=%0d exp=0", mem_addr, mem_wdata, err_addr); end
    rst = 1'b0;
    tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL idle_s_ready got=%0h exp=0", s_ready); end
  endtask

  task automatic test_encode();
    pulse_start();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL load_s_ready got=%0h exp=1", s_ready); end
    s_valid = 1'b1; s_upper = 5'b10101; s_imm = 8'hFD;
    tick();
    s_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL t1_mem_we got=%0h exp=1", mem_we); end
    checks++; if (mem_addr !== 4'd0) begin failures++; $display("FAIL t1_addr got=%0d exp=0", mem_addr); end
    checks++; if (mem_wdata !== 8'hAD) begin failures++; $display("FAIL t1_wdata got=%0h exp=ad", mem_wdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t1_err got=%0h exp=0", err); end
    checks++; if (wr_count !== 5'd1) begin failures++; $display("FAIL t1_wr_count got=%0d exp=1", wr_count); end
    tick();
    checks++; if (mem_we !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 8'hAD) begin
      failures++; $display("FAIL t1_idle_hold got we=%0h addr=%0d wdata=%0h exp we=0 addr=0 wdata=ad", mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_range_err();
    s_valid = 1'b1; s_upper = 5'h00; s_imm = 8'h01;
    tick();
    checks++; if (mem_addr !== 4'd1 || mem_wdata !== 8'h01 || err !== 1'b0) begin
      failures++; $display("FAIL t2_legal got addr=%0d wdata=%0h err=%0h exp addr=1 wdata=01 err=0", mem_addr, mem_wdata, err); end
    s_upper = 5'h03; s_imm = 8'h04;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 4'd2 || mem_wdata !== 8'h1C) begin
      failures++; $display("FAIL t2_write got we=%0h addr=%0d wdata=%0h exp we=1 addr=2 wdata=1c", mem_we, mem_addr, mem_wdata); end
    checks++; if (err !== 1'b1 || err_count !== 4'd1 || err_addr !== 4'd2) begin
      failures++; $display("FAIL t2_err got err=%0h cnt=%0d addr=%0d exp 1/1/2", err, err_count, err_addr); end
    s_upper = 5'h1F; s_imm = 8'h80; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (mem_addr !== 4'd3 || mem_wdata !== 8'hF8) begin
      failures++; $display("FAIL t2_second_bad got addr=%0d wdata=%0h exp addr=3 wdata=f8", mem_addr, mem_wdata); end
    checks++; if (err_count !== 4'd2 || err_addr !== 4'd2) begin
      failures++; $display("FAIL t2_err_addr_kept got cnt=%0d addr=%0d exp 2/2", err_count, err_addr); end
    checks++; if (done !== 1'b1 || s_ready !== 1'b0 || wr_count !== 5'd4) begin
      failures++; $display("FAIL t2_done got done=%0h rdy=%0h cnt=%0d exp 1/0/4", done, s_ready, wr_count); end
    tick();
    checks++; if (mem_we !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL t2_done_hold got we=%0h done=%0h exp 0/1", mem_we, done); end
  endtask

  task automatic test_restart();
    pulse_start();
    checks++; if (done !== 1'b0 || s_ready !== 1'b1 || wr_count !== 5'd0) begin
      failures++; $display("FAIL t6_restart_ctrl got done=%0h rdy=%0h cnt=%0d exp 0/1/0", done, s_ready, wr_count); end
    checks++; if (err !== 1'b0 || err_count !== 4'd0 || err_addr !== 4'd0) begin
      failures++; $display("FAIL t6_restart_err got err=%0h cnt=%0d addr=%0d exp 0/0/0", err, err_count, err_addr); end
    s_valid = 1'b1; s_upper = 5'h01; s_imm = 8'h02;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 8'h0A || wr_count !== 5'd1) begin
      failures++; $display("FAIL t6_first_write got we=%0h addr=%0d wdata=%0h cnt=%0d exp 1/0/0a/1", mem_we, mem_addr, mem_wdata, wr_count); end
  endtask

  task automatic test_start_ignored();
    start = 1'b1; s_upper = 5'h02; s_imm = 8'hFF;
    tick();
    start = 1'b0;
    checks++; if (mem_addr !== 4'd1 || mem_wdata !== 8'h17 || wr_count !== 5'd2 || s_ready !== 1'b1) begin
      failures++; $display("FAIL t6_start_ignored got addr=%0d wdata=%0h cnt=%0d rdy=%0h exp 1/17/2/1", mem_addr, mem_wdata, wr_count, s_ready); end
  endtask

  task automatic test_last();
    s_upper = 5'h03; s_imm = 8'h00; s_last = 1'b1;
    tick();
    s_last = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 4'd2 || mem_wdata !== 8'h18 || wr_count !== 5'd3) begin
      failures++; $display("FAIL t3_last_write got we=%0h addr=%0d wdata=%0h cnt=%0d exp 1/2/18/3", mem_we, mem_addr, mem_wdata, wr_count); end
    checks++; if (done !== 1'b1 || s_ready !== 1'b0) begin
      failures++; $display("FAIL t3_done got done=%0h rdy=%0h exp 1/0", done, s_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (mem_we !== 1'b0 || wr_count !== 5'd3 || mem_addr !== 4'd2) begin
        failures++; $display("FAIL t3_ignored got we=%0h cnt=%0d addr=%0d exp 0/3/2", mem_we, wr_count, mem_addr); end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_full();
    logic [4:0] u;
    pulse_start();
    s_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      u = 5'(i);
      s_upper = u; s_imm = se3(u[2:0]);
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== {u, u[2:0]} || done !== (i == DEPTH - 1)) begin
        failures++; $display("FAIL t4_write%0d got we=%0h addr=%0d wdata=%0h done=%0h exp 1/%0d/%0h/%0d", i, mem_we, mem_addr, mem_wdata, done, i, {u, u[2:0]}, (i == DEPTH - 1)); end
    end
    checks++; if (wr_count !== 5'd16 || s_ready !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL t4_full got cnt=%0d rdy=%0h err=%0h exp 16/0/0", wr_count, s_ready, err); end
    tick();
    s_valid = 1'b0;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 4'd15) begin
      failures++; $display("FAIL t4_no_wrap got we=%0h addr=%0d exp 0/15", mem_we, mem_addr); end
  endtask

  task automatic test_random_legal();
    int v;
    for (int load = 0; load < 2; load++) begin
      pulse_start();
      s_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        v = int'($urandom_range(0, 7)) - 4;
        s_imm = 8'(v); s_upper = 5'($urandom_range(0, 31)); s_last = (k == 9);
        tick();
        checks++; if (se3(mem_wdata[2:0]) !== s_imm || mem_wdata[7:3] !== s_upper || mem_addr !== AW'(k) || err !== 1'b0) begin
          failures++; $display("FAIL rand_imm got wdata=%0h addr=%0d err=%0h exp imm=%0h upper=%0h addr=%0d err=0", mem_wdata, mem_addr, err, s_imm, s_upper, k); end
      end
      s_valid = 1'b0; s_last = 1'b0;
      checks++; if (done !== 1'b1 || wr_count !== 5'd10) begin
        failures++; $display("FAIL rand_done got done=%0h cnt=%0d exp 1/10", done, wr_count); end
    end
  endtask

  task automatic test_err_sat();
    pulse_start();
    s_valid = 1'b1; s_upper = 5'h00; s_imm = 8'h40;
    for (int k = 0; k < DEPTH; k++) tick();
    s_valid = 1'b0;
    checks++; if (err !== 1'b1 || err_count !== 4'd15 || err_addr !== 4'd0) begin
      failures++; $display("FAIL err_sat got err=%0h cnt=%0d addr=%0d exp 1/15/0", err, err_count, err_addr); end
    checks++; if (mem_wdata !== 8'h00 || wr_count !== 5'd16 || done !== 1'b1) begin
      failures++; $display("FAIL err_sat_write got wdata=%0h cnt=%0d done=%0h exp 00/16/1", mem_wdata, wr_count, done); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    s_valid = 1'b1; s_upper = 5'h05; s_imm = 8'h10;
    tick();
    checks++; if (err_count !== 4'd1 || mem_we !== 1'b1) begin
      failures++; $display("FAIL t5_pre got cnt=%0d we=%0h exp 1/1", err_count, mem_we); end
    rst = 1'b1;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    checks++; if (mem_we !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL t5_ctrl got we=%0h rdy=%0h done=%0h exp 0/0/0", mem_we, s_ready, done); end
    checks++; if (wr_count !== 5'd0 || err_count !== 4'd0 || err !== 1'b0 || err_addr !== 4'd0) begin
      failures++; $display("FAIL t5_counters got cnt=%0d ecnt=%0d err=%0h eaddr=%0d exp 0", wr_count, err_count, err, err_addr); end
    checks++; if (mem_addr !== 4'd0 || mem_wdata !== 8'h00) begin
      failures++; $display("FAIL t5_data got addr=%0d wdata=%0h exp 0/00", mem_addr, mem_wdata); end
    tick();
    checks++; if (s_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL t5_idle got rdy=%0h we=%0h exp 0/0", s_ready, mem_we); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_range_err();
    test_restart();
    test_start_ignored();
    test_last();
    test_full();
    test_random_legal();
    test_err_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
